// File: rtl/radmon_pkg.sv
// Shared types and constants for the radiation monitor collector.
// Imported by the collector top and its interface users.
package radmon_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int DROP_W = 8;

  function automatic logic [DROP_W-1:0] sat_inc(
    input logic [DROP_W-1:0] v
  );
    return (&v) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/radiation_monitor_collector_if.sv
// Word stream from the collector to its consumer.
// Valid/ready handshake with channel index and last flag.
interface radiation_monitor_collector_if #(
  parameter int W = 8,
  parameter int N = 8
);
  localparam int CW = $clog2(N);

  logic [W-1:0]  data_o;
  logic [CW-1:0] chan_o;
  logic          last_o;
  logic          valid_o;
  logic          ready_i;

  modport master (
    output data_o,
    output chan_o,
    output last_o,
    output valid_o,
    input  ready_i
  );

  modport slave (
    input  data_o,
    input  chan_o,
    input  last_o,
    input  valid_o,
    output ready_i
  );
endinterface

// File: rtl/radiation_monitor_period_timer.sv
// Free-running snapshot period timer.
// Pulses expire_o on the terminal count; a zero period disables it.
module radiation_monitor_period_timer #(
  parameter int G_PERIOD_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic expire_o
);

  generate
    if (G_PERIOD_CYCLES == 0) begin : g_off
      logic w_unused;
      assign w_unused = clk_i ^ rst_ni;
      assign expire_o = 1'b0;
    end else begin : g_on
      localparam int TW =
        (G_PERIOD_CYCLES > 1) ? $clog2(G_PERIOD_CYCLES) : 1;
      localparam logic [TW-1:0] TC = TW'(G_PERIOD_CYCLES - 1);

      logic [TW-1:0] r_cnt;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_cnt <= '0;
        end else if (r_cnt == TC) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign expire_o = (r_cnt == TC);
    end
  endgenerate

endmodule

// File: rtl/radiation_monitor_collector.sv
// Radiation monitor snapshot collector.
// Latches all channel counters on a trigger and streams one word each.
module radiation_monitor_collector
  import radmon_pkg::*;
#(
  parameter int G_NUM_CHANNELS  = 8,
  parameter int G_COUNTER_WIDTH = 8,
  parameter int G_PERIOD_CYCLES = 1000000,
  parameter int G_DELTA_MODE    = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic [G_NUM_CHANNELS*G_COUNTER_WIDTH-1:0] counters_i,
  input  logic snapshot_i,
  radiation_monitor_collector_if.master stream,
  output logic busy_o,
  output logic [DROP_W-1:0] dropped_o
);

  localparam int N  = G_NUM_CHANNELS;
  localparam int W  = G_COUNTER_WIDTH;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_idx;
  logic [CW-1:0]     w_idx_nxt;
  logic [W-1:0]      r_snap [N];
  logic [W-1:0]      w_base;
  logic [W-1:0]      w_word;
  logic [DROP_W-1:0] r_dropped;
  logic              w_expire;
  logic              w_trig;
  logic              w_valid;
  logic              w_last;
  logic              w_hs;
  logic              w_cap;
  logic              w_drop;

  // Assert immediately, release two clean edges after rst_ni rises.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rst_sync <= '0;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  radiation_monitor_period_timer #(
    .G_PERIOD_CYCLES(G_PERIOD_CYCLES)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (w_rst_n),
    .expire_o(w_expire)
  );

  assign w_trig  = snapshot_i | w_expire;
  assign w_valid = (r_state == SEND);
  assign w_last  = (r_idx == LAST_IDX);
  assign w_hs    = w_valid & stream.ready_i;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cap       = 1'b0;
    w_drop      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_trig) begin
          w_cap       = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        w_drop = w_trig;
        if (w_hs) begin
          if (w_last) begin
            w_idx_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_dropped <= '0;
    end else if (w_drop) begin
      r_dropped <= sat_inc(r_dropped);
    end
  end

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int k = 0; k < N; k++) begin
        r_snap[k] <= '0;
      end
    end else if (w_cap) begin
      for (int k = 0; k < N; k++) begin
        r_snap[k] <= counters_i[k*W +: W];
      end
    end
  end

  generate
    if (G_DELTA_MODE != 0) begin : g_delta
      logic [W-1:0] r_prev [N];

      always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
          for (int k = 0; k < N; k++) begin
            r_prev[k] <= '0;
          end
        end else if (w_cap) begin
          for (int k = 0; k < N; k++) begin
            r_prev[k] <= r_snap[k];
          end
        end
      end

      assign w_base = r_prev[r_idx];
    end else begin : g_raw
      assign w_base = '0;
    end
  endgenerate

  // Modular subtraction gives the correct delta across counter wrap.
  assign w_word = r_snap[r_idx] - w_base;

  assign stream.valid_o = w_valid;
  assign stream.data_o  = w_valid ? w_word : '0;
  assign stream.chan_o  = r_idx;
  assign stream.last_o  = w_valid & w_last;
  assign busy_o         = w_valid;
  assign dropped_o      = r_dropped;

endmodule

// File: tb/tb_radiation_monitor_collector.sv
// Bench for radiation_monitor_collector: raw, delta and timer builds.
// Directed scenarios plus a randomized run against a word-queue model.
module tb_radiation_monitor_collector;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic rst_a = 1'b1;
  logic rst_d = 1'b1;
  logic rst_t = 1'b1;
  logic [N*W-1:0] cnt_a = '0;
  logic [N*W-1:0] cnt_d = '0;
  logic [N*W-1:0] cnt_t = '0;
  logic snap_a = 1'b0;
  logic snap_d = 1'b0;
  logic snap_t = 1'b0;
  logic busy_a, busy_d, busy_t;
  logic [7:0] drop_a, drop_d, drop_t;

  radiation_monitor_collector_if #(.W(W), .N(N)) if_a ();
  radiation_monitor_collector_if #(.W(W), .N(N)) if_d ();
  radiation_monitor_collector_if #(.W(W), .N(N)) if_t ();

  radiation_monitor_collector #(
    .G_NUM_CHANNELS(N), .G_COUNTER_WIDTH(W),
    .G_PERIOD_CYCLES(0), .G_DELTA_MODE(0)
  ) u_raw (
    .clk_i(clk), .rst_ni(rst_a), .counters_i(cnt_a),
    .snapshot_i(snap_a), .stream(if_a),
    .busy_o(busy_a), .dropped_o(drop_a)
  );

  radiation_monitor_collector #(
    .G_NUM_CHANNELS(N), .G_COUNTER_WIDTH(W),
    .G_PERIOD_CYCLES(0), .G_DELTA_MODE(1)
  ) u_dlt (
    .clk_i(clk), .rst_ni(rst_d), .counters_i(cnt_d),
    .snapshot_i(snap_d), .stream(if_d),
    .busy_o(busy_d), .dropped_o(drop_d)
  );

  radiation_monitor_collector #(
    .G_NUM_CHANNELS(N), .G_COUNTER_WIDTH(W),
    .G_PERIOD_CYCLES(20), .G_DELTA_MODE(0)
  ) u_tmr (
    .clk_i(clk), .rst_ni(rst_t), .counters_i(cnt_t),
    .snapshot_i(snap_t), .stream(if_t),
    .busy_o(busy_t), .dropped_o(drop_t)
  );

  // Model of the raw build: words still owed to the consumer.
  logic [W-1:0] q_a[$];
  int exp_drop_a = 0;

  function automatic void model_a(input bit s, input bit r);
    if (q_a.size() != 0) begin
      if (s && exp_drop_a < 255) exp_drop_a++;
      if (r) void'(q_a.pop_front());
    end else if (s) begin
      for (int k = 0; k < N; k++) q_a.push_back(cnt_a[k*W +: W]);
    end
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst_a = 1'b0; rst_d = 1'b0; rst_t = 1'b0;
    if_a.ready_i = 1'b0; if_d.ready_i = 1'b1; if_t.ready_i = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({if_a.valid_o, busy_a, if_a.last_o} !== 3'b000 ||
        if_a.data_o !== 8'd0 || if_a.chan_o !== 2'd0 || drop_a !== 8'd0) begin
      failures++;
      $display("FAIL reset_raw: v=%b b=%b l=%b d=%0d c=%0d dr=%0d, all must be 0",
               if_a.valid_o, busy_a, if_a.last_o, if_a.data_o, if_a.chan_o, drop_a);
    end
    checks++;
    if ({if_d.valid_o, busy_d, if_d.last_o} !== 3'b000 ||
        if_d.data_o !== 8'd0 || if_d.chan_o !== 2'd0 || drop_d !== 8'd0) begin
      failures++;
      $display("FAIL reset_delta: v=%b d=%0d c=%0d dr=%0d, all must be 0",
               if_d.valid_o, if_d.data_o, if_d.chan_o, drop_d);
    end
    checks++;
    if ({if_t.valid_o, busy_t, if_t.last_o} !== 3'b000 ||
        if_t.data_o !== 8'd0 || if_t.chan_o !== 2'd0 || drop_t !== 8'd0) begin
      failures++;
      $display("FAIL reset_timer: v=%b d=%0d c=%0d dr=%0d, all must be 0",
               if_t.valid_o, if_t.data_o, if_t.chan_o, drop_t);
    end
    rst_a = 1'b1; rst_d = 1'b1; rst_t = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (if_a.valid_o !== 1'b0 || if_d.valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: valid raw=%b delta=%b, required 0",
               if_a.valid_o, if_d.valid_o);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] exp_w [N];
    exp_w = '{8'd3, 8'd7, 8'd0, 8'd255};
    cnt_a = {8'd255, 8'd0, 8'd7, 8'd3};
    if_a.ready_i = 1'b1;
    snap_a = 1'b1;
    @(negedge clk);
    snap_a = 1'b0;
    cnt_a = $urandom;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (if_a.valid_o !== 1'b1 || busy_a !== 1'b1 ||
          if_a.chan_o !== 2'(i) || if_a.data_o !== exp_w[i] ||
          if_a.last_o !== (i == N - 1)) begin
        failures++;
        $display("FAIL basic_word%0d: v=%b c=%0d d=%0d l=%b, required v=1 c=%0d d=%0d l=%b",
                 i, if_a.valid_o, if_a.chan_o, if_a.data_o, if_a.last_o,
                 i, exp_w[i], (i == N - 1));
      end
      cnt_a = $urandom;
      @(negedge clk);
    end
    checks++;
    if (if_a.valid_o !== 1'b0 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL basic_end: v=%b busy=%b, required 0 0", if_a.valid_o, busy_a);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp_w [N];
    int n = 0;
    int stall = 0;
    for (int k = 0; k < N; k++) exp_w[k] = W'($urandom);
    for (int k = 0; k < N; k++) cnt_a[k*W +: W] = exp_w[k];
    if_a.ready_i = 1'b1;
    snap_a = 1'b1;
    @(negedge clk);
    snap_a = 1'b0;
    for (int cyc = 0; cyc < 40 && n < N; cyc++) begin
      cnt_a = $urandom;
      if (if_a.valid_o) begin
        checks++;
        if (if_a.chan_o !== 2'(n) || if_a.data_o !== exp_w[n]) begin
          failures++;
          $display("FAIL bp_word: c=%0d d=%0d, required c=%0d d=%0d",
                   if_a.chan_o, if_a.data_o, n, exp_w[n]);
        end
        if (n == 1 && stall < 5) begin
          if_a.ready_i = 1'b0;
          stall++;
        end else begin
          if_a.ready_i = 1'b1;
          n++;
        end
      end else begin
        if_a.ready_i = 1'b1;
      end
      @(negedge clk);
    end
    checks++;
    if (n != N || stall != 5 || if_a.valid_o !== 1'b0) begin
      failures++;
      $display("FAIL bp_total: words=%0d stalls=%0d v=%b, required 4 5 0",
               n, stall, if_a.valid_o);
    end
  endtask

  task automatic test_drop();
    logic [W-1:0] w0;
    w0 = W'($urandom);
    cnt_a = {24'h0, w0};
    if_a.ready_i = 1'b0;
    snap_a = 1'b1;
    @(negedge clk);
    cnt_a = $urandom;
    @(negedge clk);
    @(negedge clk);
    snap_a = 1'b0;
    checks++;
    if (drop_a !== 8'd2) begin
      failures++;
      $display("FAIL drop_two: dropped=%0d, required 2", drop_a);
    end
    for (int i = 0; i < 300; i++) begin
      snap_a = 1'b1;
      if (i == 252) begin
        checks++;
        if (drop_a !== 8'd254) begin
          failures++;
          $display("FAIL drop_254: dropped=%0d, required 254", drop_a);
        end
      end
      @(negedge clk);
    end
    snap_a = 1'b0;
    @(negedge clk);
    checks++;
    if (drop_a !== 8'd255 || if_a.chan_o !== 2'd0 || if_a.data_o !== w0) begin
      failures++;
      $display("FAIL drop_sat: dropped=%0d c=%0d d=%0d, required 255 0 %0d",
               drop_a, if_a.chan_o, if_a.data_o, w0);
    end
    if_a.ready_i = 1'b1;
    repeat (N) @(negedge clk);
    checks++;
    if (if_a.valid_o !== 1'b0 || drop_a !== 8'd255) begin
      failures++;
      $display("FAIL drop_drain: v=%b dropped=%0d, required 0 255",
               if_a.valid_o, drop_a);
    end
  endtask

  task automatic test_reset_mid_send();
    logic [W-1:0] exp_w [N];
    int seen = 0;
    if_a.ready_i = 1'b1;
    snap_a = 1'b1;
    @(negedge clk);
    snap_a = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (if_a.chan_o !== 2'd2 || if_a.valid_o !== 1'b1) begin
      failures++;
      $display("FAIL rmid_pre: c=%0d v=%b, required 2 1", if_a.chan_o, if_a.valid_o);
    end
    if_a.ready_i = 1'b0;
    rst_a = 1'b0;
    #1;
    checks++;
    if (if_a.valid_o !== 1'b0 || busy_a !== 1'b0 || drop_a !== 8'd0 ||
        if_a.chan_o !== 2'd0 || if_a.data_o !== 8'd0) begin
      failures++;
      $display("FAIL rmid_async: v=%b b=%b dr=%0d c=%0d d=%0d, all must be 0",
               if_a.valid_o, busy_a, drop_a, if_a.chan_o, if_a.data_o);
    end
    @(negedge clk);
    rst_a = 1'b1;
    if_a.ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_a.valid_o !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rmid_quiet: valid cycles=%0d, required 0", seen);
    end
    for (int k = 0; k < N; k++) exp_w[k] = W'($urandom);
    for (int k = 0; k < N; k++) cnt_a[k*W +: W] = exp_w[k];
    snap_a = 1'b1;
    @(negedge clk);
    snap_a = 1'b0;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (if_a.valid_o !== 1'b1 || if_a.chan_o !== 2'(i) || if_a.data_o !== exp_w[i]) begin
        failures++;
        $display("FAIL rmid_new%0d: v=%b c=%0d d=%0d, required 1 %0d %0d",
                 i, if_a.valid_o, if_a.chan_o, if_a.data_o, i, exp_w[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random_raw();
    bit s, r, ev;
    q_a.delete();
    exp_drop_a = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      ev = (q_a.size() != 0);
      checks++;
      if (if_a.valid_o !== ev || busy_a !== ev || drop_a !== 8'(exp_drop_a)) begin
        failures++;
        $display("FAIL rand_state@%0d: v=%b b=%b dr=%0d, required v=%b dr=%0d",
                 cyc, if_a.valid_o, busy_a, drop_a, ev, exp_drop_a);
      end
      if (ev) begin
        checks++;
        if (if_a.chan_o !== 2'(N - q_a.size()) || if_a.data_o !== q_a[0] ||
            if_a.last_o !== (q_a.size() == 1)) begin
          failures++;
          $display("FAIL rand_word@%0d: c=%0d d=%0d l=%b, required c=%0d d=%0d l=%b",
                   cyc, if_a.chan_o, if_a.data_o, if_a.last_o,
                   N - q_a.size(), q_a[0], (q_a.size() == 1));
        end
      end
      cnt_a = $urandom;
      s = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 3) != 0);
      snap_a = s;
      if_a.ready_i = r;
      model_a(s, r);
      @(negedge clk);
    end
    snap_a = 1'b0;
  endtask

  task automatic test_delta();
    logic [W-1:0] prev [N];
    logic [W-1:0] cur [N];
    logic [W-1:0] exp_v;
    for (int k = 0; k < N; k++) prev[k] = '0;
    if_d.ready_i = 1'b1;
    for (int rnd = 0; rnd < 6; rnd++) begin
      for (int k = 0; k < N; k++) cur[k] = W'($urandom);
      if (rnd == 0) cur[0] = 8'd250;
      if (rnd == 1) cur[0] = 8'd4;
      for (int k = 0; k < N; k++) cnt_d[k*W +: W] = cur[k];
      snap_d = 1'b1;
      @(negedge clk);
      snap_d = 1'b0;
      cnt_d = $urandom;
      for (int i = 0; i < N; i++) begin
        exp_v = W'((int'(cur[i]) - int'(prev[i]) + 256) % 256);
        checks++;
        if (if_d.valid_o !== 1'b1 || if_d.chan_o !== 2'(i) || if_d.data_o !== exp_v) begin
          failures++;
          $display("FAIL delta_r%0d_c%0d: v=%b c=%0d d=%0d, required 1 %0d %0d",
                   rnd, i, if_d.valid_o, if_d.chan_o, if_d.data_o, i, exp_v);
        end
        if (rnd == 1 && i == 0) begin
          checks++;
          if (if_d.data_o !== 8'd10) begin
            failures++;
            $display("FAIL delta_wrap: d=%0d, required 10", if_d.data_o);
          end
        end
        @(negedge clk);
      end
      for (int k = 0; k < N; k++) prev[k] = cur[k];
      checks++;
      if (if_d.valid_o !== 1'b0) begin
        failures++;
        $display("FAIL delta_end%0d: v=%b, required 0", rnd, if_d.valid_o);
      end
    end
  endtask

  task automatic test_timer();
    int rises[$];
    int words = 0;
    bit pv = 1'b0;
    if_t.ready_i = 1'b1;
    snap_t = 1'b0;
    rst_t = 1'b0;
    @(negedge clk);
    rst_t = 1'b1;
    for (int cyc = 0; cyc < 130; cyc++) begin
      @(negedge clk);
      if (if_t.valid_o === 1'b1) words++;
      if (if_t.valid_o === 1'b1 && !pv) begin
        rises.push_back(cyc);
        checks++;
        if (if_t.chan_o !== 2'd0 || if_t.data_o !== cnt_t[W-1:0]) begin
          failures++;
          $display("FAIL timer_first@%0d: c=%0d d=%0d, required 0 %0d",
                   cyc, if_t.chan_o, if_t.data_o, cnt_t[W-1:0]);
        end
      end
      pv = (if_t.valid_o === 1'b1);
      cnt_t = $urandom;
      snap_t = (cyc == 100);
    end
    snap_t = 1'b0;
    checks++;
    if (rises.size() != 6) begin
      failures++;
      $display("FAIL timer_count: snapshots=%0d, required 6", rises.size());
    end
    for (int i = 0; i < rises.size() && i < 6; i++) begin
      checks++;
      if (rises[i] != 21 + 20 * i) begin
        failures++;
        $display("FAIL timer_phase%0d: start=%0d, required %0d", i, rises[i], 21 + 20 * i);
      end
    end
    checks++;
    if (words != 6 * N || drop_t !== 8'd0) begin
      failures++;
      $display("FAIL timer_words: words=%0d dropped=%0d, required %0d 0",
               words, drop_t, 6 * N);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_drop();
    test_reset_mid_send();
    test_random_raw();
    test_delta();
    test_timer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/radiation_monitor_collector.md
RADIATION_MONITOR_COLLECTOR -- requirements
Module: radiation_monitor_collector

Interface
REQ-001 Parameter G_NUM_CHANNELS, default 8, number of monitored channels (2..64).
REQ-002 Parameter G_COUNTER_WIDTH, default 8, width of each channel counter.
REQ-003 Parameter G_PERIOD_CYCLES, default 1000000, automatic snapshot period in clk_i cycles; 0 disables the timer.
REQ-004 Parameter G_DELTA_MODE, default 0; 1 outputs the difference since the previous snapshot, 0 outputs the raw value.
REQ-005 clk_i  input  1  single clock; all logic is on its rising edge.
REQ-006 rst_ni  input  1  asynchronous, active-low reset.
REQ-007 counters_i  input  G_NUM_CHANNELS*G_COUNTER_WIDTH  packed channel counters; channel k occupies bits [k*W +: W].
REQ-008 snapshot_i  input  1  single-cycle snapshot request.
REQ-009 data_o  output  G_COUNTER_WIDTH  value for the current channel.
REQ-010 chan_o  output  $clog2(G_NUM_CHANNELS)  index of the current channel.
REQ-011 last_o  output  1  high with the word of channel G_NUM_CHANNELS-1.
REQ-012 valid_o  output  1  word valid; ready_i  input  1  consumer accepts the word.
REQ-013 busy_o  output  1  high while a snapshot is being sent.
REQ-014 dropped_o  output  8  saturating count of triggers lost while busy.

Function
REQ-015 Two-state FSM: IDLE and SEND.
REQ-016 Trigger = snapshot_i OR timer expiry; simultaneous sources in one cycle form one trigger.
REQ-017 In IDLE, a trigger at edge t latches all counters_i into snapshot registers, sets the index to 0 and enters SEND; valid_o is high from cycle t+1.
REQ-018 In SEND, valid_o = 1 and busy_o = 1; data_o, chan_o and last_o stay stable while valid_o && !ready_i.
REQ-019 A handshake (valid_o && ready_i) on index i < N-1 advances the index to i+1 on the next cycle with no bubble.
REQ-020 A handshake on index N-1 returns to IDLE; valid_o and busy_o are low on the next cycle.
REQ-021 A trigger that occurs in SEND, including on the final handshake cycle, does not capture and increments dropped_o, which saturates at 255.
REQ-022 The timer counts 0..G_PERIOD_CYCLES-1 free-running in both states and expires on the terminal count, then reloads to 0; it runs regardless of FSM state.
REQ-023 With G_DELTA_MODE=1, each capture copies the old snapshot into the previous registers before loading the new values; data_o = (snap[i] - prev[i]) mod 2^W, so counter wrap yields the correct modular delta.
REQ-024 With G_DELTA_MODE=0, data_o = snap[i].
REQ-025 counters_i changes after capture do not affect words in flight.

Reset
REQ-026 When rst_ni = 0, the block immediately and asynchronously enters IDLE and clears the following to 0: index, timer, snapshot registers, previous registers and dropped_o.
REQ-027 In reset, all outputs are 0: valid_o, busy_o, last_o, data_o, chan_o and dropped_o.
REQ-028 A reset asserted mid-SEND abandons the snapshot; no word is emitted after release until a new trigger occurs.
REQ-029 Reset release is synchronised to clk_i (a 2-flop release synchroniser), so the FSM leaves reset on a clean edge.

Structure
REQ-030 Shared package radmon_pkg holds the FSM state enum typedef (IDLE, SEND) and the dropped-counter width constant (8).
REQ-031 The period timer is the sub-module radiation_monitor_period_timer, with parameter G_PERIOD_CYCLES and output expire_o (one-cycle pulse); with G_PERIOD_CYCLES=0, expire_o is tied to 0.
REQ-032 The channel output mux is combinational from the index over the snapshot (and previous) registers.

Verification
REQ-033 N=4, W=8, raw mode, ready_i=1; counters {3,7,0,255}; snapshot_i pulse at cycle 10 -> words at cycles 11..14: chan 0..3, data 3,7,0,255, last_o only at cycle 14; busy_o low at cycle 15.
REQ-034 Backpressure: ready_i=0 for 5 cycles on chan 1 -> chan 1 and its data are held stable for 5 cycles; total words sent = 4, with no duplicates and no skipped channels.
REQ-035 Drop: snapshot_i pulses at cycles 12 and 13 during SEND, plus 300 further pulses while busy -> dropped_o = 2 after the first two, then saturates at 255.
REQ-036 Delta mode with wrap: channel 0 is 250 at the first snapshot, then 4 at the second -> second-snapshot data for chan 0 = 10.
REQ-037 Timer: G_PERIOD_CYCLES=20, no snapshot_i -> a snapshot starts every 20 cycles; a simultaneous snapshot_i and expiry produce one snapshot and dropped_o = 0.
REQ-038 Reset mid-SEND: rst_ni low while on chan 2 -> valid_o = 0 and dropped_o = 0 immediately; no output after release until the next trigger.
